// File: rtl/ff_real_ring_seq_if.sv
// Handshake/data bundle between the ring sequencer and whoever drives it.
// The sequencer owns the slave side; the bench or host owns the master side.
interface ff_real_ring_seq_if #(
    parameter int CNT_W = 8
);
    logic             start_i;
    logic [CNT_W-1:0] count_i;
    logic             abort_i;
    real              tail_i;
    logic             load_o;
    logic             shift_en_o;
    logic             busy_o;
    logic             done_o;
    real              sum_o;
    real              max_o;
    logic [CNT_W-1:0] shifts_o;

    modport slave (
        input  start_i, count_i, abort_i, tail_i,
        output load_o, shift_en_o, busy_o, done_o, sum_o, max_o, shifts_o
    );

    modport master (
        output start_i, count_i, abort_i, tail_i,
        input  load_o, shift_en_o, busy_o, done_o, sum_o, max_o, shifts_o
    );
endinterface

// File: rtl/ff_real_ring_seq.sv
// Sequencer for a real-valued flip-flop shift ring: load the ring, clock it a
// programmed number of times and accumulate sum/max of the scaled tail value.
// Simulation-only (real arithmetic). All outputs come straight from flops.
module ff_real_ring_seq #(
    parameter int  SR_W  = 8,
    parameter int  CNT_W = 8,
    parameter real SCALE = 1.0
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    ff_real_ring_seq_if.slave    bus
);

    // Ring length only matters to the bench; catch nonsense values at elaboration.
    if (SR_W < 1 || CNT_W < 1) begin : g_param_chk
        $error("ff_real_ring_seq: SR_W and CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] shifts_q, shifts_d;
    real              sum_q, sum_d;
    real              max_q, max_d;
    real              samp;
    logic             load_q, load_d;
    logic             shift_q, shift_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state, accumulator update and strobe decode of the next state.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        shifts_d = shifts_q;
        sum_d    = sum_q;
        max_d    = max_q;
        samp     = SCALE * bus.tail_i;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    // Results are cleared on acceptance so they read 0 during LOAD
                    // (or immediately, for a zero-count start).
                    sum_d    = 0.0;
                    max_d    = 0.0;
                    shifts_d = '0;
                    if (bus.count_i != '0) begin
                        rem_d   = bus.count_i;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                state_d = bus.abort_i ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                if (bus.abort_i) begin
                    // Abort wins over the final shift; partial results hold.
                    state_d = S_IDLE;
                end else begin
                    sum_d    = sum_q + samp;
                    max_d    = (shifts_q == '0 || samp > max_q) ? samp : max_q;
                    shifts_d = shifts_q + CNT_W'(1);
                    rem_d    = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        load_d  = (state_d == S_LOAD);
        shift_d = (state_d == S_SHIFT);
        busy_d  = load_d | shift_d;
        done_d  = (state_d == S_DONE);
    end

    // State, counters, accumulators and registered strobes.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            shifts_q <= '0;
            sum_q    <= 0.0;
            max_q    <= 0.0;
            load_q   <= 1'b0;
            shift_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            shifts_q <= shifts_d;
            sum_q    <= sum_d;
            max_q    <= max_d;
            load_q   <= load_d;
            shift_q  <= shift_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.load_o     = load_q;
    assign bus.shift_en_o = shift_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.sum_o      = sum_q;
    assign bus.max_o      = max_q;
    assign bus.shifts_o   = shifts_q;

endmodule

// File: tb/tb_ff_real_ring_seq.sv
// Bench for ff_real_ring_seq: directed scenarios plus randomized runs, each
// checked against a sequence-level model (list of tail samples -> sum/max/count).
module tb_ff_real_ring_seq;

    localparam int  CNT_W = 8;
    localparam real SCALE = 2.0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ff_real_ring_seq_if #(.CNT_W(CNT_W)) bus();

    ff_real_ring_seq #(.SR_W(8), .CNT_W(CNT_W), .SCALE(SCALE)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    int  ncmp = 0;
    int  nerr = 0;
    int  n_done = 0;
    real exp_sum, exp_max;
    int  exp_n;
    real tq[$];

    // Count every done pulse seen at a rising edge.
    always @(posedge clk) if (bus.done_o === 1'b1) n_done++;

    task automatic chk_b(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input real obs, input real exp);
        ncmp++;
        assert (obs == exp) else begin
            nerr++;
            $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_clr();
        exp_sum = 0.0;
        exp_max = 0.0;
        exp_n   = 0;
    endtask

    task automatic model_sample(input real t);
        real s;
        s = SCALE * t;
        if (exp_n == 0 || s > exp_max) exp_max = s;
        exp_sum = exp_sum + s;
        exp_n++;
    endtask

    task automatic chk_res(input string tag);
        chk_r({tag, "_sum"}, bus.sum_o, exp_sum);
        chk_r({tag, "_max"}, bus.max_o, exp_max);
        chk_b({tag, "_shifts"}, int'(bus.shifts_o), exp_n);
    endtask

    function automatic real rnd_tail();
        return real'(int'($urandom_range(0, 4000)) - 2000) / 100.0;
    endfunction

    // One sequence from IDLE: n shifts, optional abort / reset on shift cycle
    // abort_at / rst_at (1-based), optional start re-assert while shifting.
    task automatic run(input string tag, input int n, input int abort_at,
                       input int rst_at, input bit restart);
        int  d0;
        real t;
        d0 = n_done;
        bus.start_i = 1'b1;
        bus.count_i = CNT_W'(n);
        step();
        bus.start_i = 1'b0;
        bus.count_i = CNT_W'($urandom);
        model_clr();
        if (n == 0) begin
            chk_b({tag, "_z_done"}, int'(bus.done_o), 1);
            chk_b({tag, "_z_load"}, int'(bus.load_o), 0);
            chk_b({tag, "_z_shift"}, int'(bus.shift_en_o), 0);
            chk_b({tag, "_z_busy"}, int'(bus.busy_o), 0);
            chk_res({tag, "_z"});
            step();
            chk_b({tag, "_z_done_clr"}, int'(bus.done_o), 0);
            chk_b({tag, "_z_ndone"}, n_done - d0, 1);
            return;
        end
        chk_b({tag, "_load"}, int'(bus.load_o), 1);
        chk_b({tag, "_load_busy"}, int'(bus.busy_o), 1);
        chk_b({tag, "_load_shift"}, int'(bus.shift_en_o), 0);
        chk_res({tag, "_load"});
        step();
        for (int i = 1; i <= n; i++) begin
            chk_b({tag, "_shift_en"}, int'(bus.shift_en_o), 1);
            chk_b({tag, "_shift_busy"}, int'(bus.busy_o), 1);
            chk_b({tag, "_shift_load"}, int'(bus.load_o), 0);
            chk_b({tag, "_shift_done"}, int'(bus.done_o), 0);
            chk_b({tag, "_shift_cnt"}, int'(bus.shifts_o), exp_n);
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_b({tag, "_rst_busy"}, int'(bus.busy_o), 0);
                chk_b({tag, "_rst_shift"}, int'(bus.shift_en_o), 0);
                model_clr();
                chk_res({tag, "_rst"});
                step();
                rst_n = 1'b1;
                step();
                chk_b({tag, "_rst_ndone"}, n_done - d0, 0);
                return;
            end
            if (i == abort_at) begin
                bus.abort_i = 1'b1;
                bus.tail_i  = 99.0;
                step();
                bus.abort_i = 1'b0;
                chk_b({tag, "_ab_busy"}, int'(bus.busy_o), 0);
                chk_b({tag, "_ab_shift"}, int'(bus.shift_en_o), 0);
                chk_b({tag, "_ab_done"}, int'(bus.done_o), 0);
                chk_res({tag, "_ab"});
                step();
                chk_b({tag, "_ab_ndone"}, n_done - d0, 0);
                chk_res({tag, "_ab_hold"});
                return;
            end
            t = (tq.size() != 0) ? tq.pop_front() : rnd_tail();
            bus.tail_i = t;
            if (restart) begin
                bus.start_i = 1'b1;
                bus.count_i = CNT_W'(9);
            end
            step();
            bus.start_i = 1'b0;
            model_sample(t);
        end
        chk_b({tag, "_done"}, int'(bus.done_o), 1);
        chk_b({tag, "_done_busy"}, int'(bus.busy_o), 0);
        chk_b({tag, "_done_shift"}, int'(bus.shift_en_o), 0);
        chk_res({tag, "_done"});
        step();
        chk_b({tag, "_done_clr"}, int'(bus.done_o), 0);
        chk_b({tag, "_ndone"}, n_done - d0, 1);
        chk_res({tag, "_hold"});
    endtask

    initial begin
        int n, ab;
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.count_i = '0;
        bus.abort_i = 1'b0;
        bus.tail_i  = 0.0;
        @(negedge clk);
        @(negedge clk);
        model_clr();
        chk_b("reset_load", int'(bus.load_o), 0);
        chk_b("reset_shift", int'(bus.shift_en_o), 0);
        chk_b("reset_busy", int'(bus.busy_o), 0);
        chk_b("reset_done", int'(bus.done_o), 0);
        chk_res("reset");
        rst_n = 1'b1;
        step();

        // T1: three samples, sum cancels
        tq = '{1.5, 2.5, -4.0};
        run("t1", 3, 0, 0, 1'b0);
        chk_r("t1_max_const", bus.max_o, 5.0);

        // T2: zero-count start
        run("t2", 0, 0, 0, 1'b0);

        // abort in IDLE is ignored
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        chk_b("idle_abort_busy", int'(bus.busy_o), 0);

        // T3: abort during 3rd shift of 5
        tq = '{3.25, -1.5};
        run("t3", 5, 3, 0, 1'b0);
        chk_r("t3_sum_const", bus.sum_o, 3.5);

        // T4: start re-asserted while shifting is ignored
        run("t4", 4, 0, 0, 1'b1);

        // T5: reset mid-shift, then a fresh sequence
        run("t5", 6, 0, 3, 1'b0);
        tq = '{0.5, 0.25};
        run("t5_after", 2, 0, 0, 1'b0);

        // T6: ring of 8, stage i reset i*1.3, tail order as the ring unloads
        tq = '{9.1, 0.0, 1.3, 2.6, 3.9, 5.2, 6.5, 7.8};
        run("t6", 8, 0, 0, 1'b0);
        chk_b("t6_sum_const", int'((bus.sum_o - 72.8) < 1e-9 && (bus.sum_o - 72.8) > -1e-9), 1);
        chk_b("t6_max_const", int'((bus.max_o - 18.2) < 1e-9 && (bus.max_o - 18.2) > -1e-9), 1);

        // T7: full-range count, constant tail
        for (int i = 0; i < 255; i++) tq.push_back(1.0);
        run("t7", 255, 0, 0, 1'b0);
        chk_r("t7_sum_const", bus.sum_o, 510.0);
        chk_b("t7_shifts_const", int'(bus.shifts_o), 255);

        // Randomized sequences, some aborted
        for (int r = 0; r < 8; r++) begin
            tq.delete();
            n  = int'($urandom_range(1, 12));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n)) : 0;
            run("rnd", n, ab, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
